lb_master: RTL and testbench
============================

Name: lb_master

Overview:
- Local-bus initiator. Converts single host commands (read or write, address, data) into one local-bus transaction at a time toward the cortex local-bus slave tree.
- Waits for the slave's valid handshake and returns one response per command to the host.
- A per-transaction timeout returns DEFAULT_DATA_VAL with an error flag, so an unmapped or hung child cannot stall the host.
- Sits between a host-side command source (UART/JTAG/soft-CPU bridge) and the top-level local-bus slave ports.

Parameters:
- LB_DATA_W, 32, local-bus data width.
- LB_ADDR_W, 16, local-bus address width.
- TIMEOUT_CYCLES, 64, cycles allowed for a valid, counted from the enable cycle; must be >= 2.
- DEFAULT_DATA_VAL, 'hdeadbabe, read data returned on a read timeout.
- TMO_CNT_W, 16, width of the saturating timeout-event counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- cmd_valid  input  1  host command present.
- cmd_ready  output  1  block can accept a command.
- cmd_wr  input  1  1 = write, 0 = read.
- cmd_addr  input  LB_ADDR_W  transaction address.
- cmd_wdata  input  LB_DATA_W  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  host accepts the response.
- rsp_data  output  LB_DATA_W  read data; 0 for writes.
- rsp_timeout  output  1  transaction timed out.
- lb_wr_en  output  1  write strobe, one-cycle pulse.
- lb_rd_en  output  1  read strobe, one-cycle pulse.
- lb_addr  output  LB_ADDR_W  bus address.
- lb_wr_data  output  LB_DATA_W  bus write data.
- lb_wr_valid  input  1  slave write acknowledge.
- lb_rd_valid  input  1  slave read data valid.
- lb_rd_data  input  LB_DATA_W  slave read data.
- tmo_cnt  output  TMO_CNT_W  saturating count of timeouts.

Behaviour:
- Reset values: all outputs 0, except cmd_ready = 1. State = IDLE, tmo_cnt = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, register cmd_wr, cmd_addr and cmd_wdata into lb_addr, lb_wr_data and the direction flag.
  - Go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Drive lb_wr_en or lb_rd_en high according to direction.
  - Clear the timeout counter.
  - Sample the matching valid this cycle, since a zero-latency slave may respond combinationally.
  - If the matching valid is present, go to RESP; otherwise go to WAIT.
- WAIT:
  - Both enables are low. lb_addr and lb_wr_data stay stable.
  - The counter increments each cycle.
  - Matching valid -> RESP with rsp_timeout = 0.
  - No valid when counter == TIMEOUT_CYCLES-1 -> RESP with rsp_timeout = 1. This gives exactly TIMEOUT_CYCLES cycles, enable cycle included.
  - A valid arriving on the cycle the timeout would fire wins; no timeout is raised.
- Matching valid:
  - Writes match on lb_wr_valid only; reads match on lb_rd_valid only.
  - A wrong-direction valid is ignored.
  - A valid seen in IDLE or RESP (late or stray) is ignored and does not corrupt the held response.
- Response data:
  - Read hit: rsp_data captures lb_rd_data on the valid cycle.
  - Read timeout: rsp_data = DEFAULT_DATA_VAL.
  - Write (hit or timeout): rsp_data = 0.
  - Each timeout increments tmo_cnt, saturating at all-ones.
- RESP:
  - rsp_valid = 1. rsp_data and rsp_timeout are held stable until rsp_valid & rsp_ready.
  - On that handshake, go to IDLE and drop rsp_valid the next cycle.
  - cmd_ready = 0 everywhere except IDLE, so there is at most one outstanding transaction.
- Minimum latency: command accept at cycle 0, enable at cycle 1, rsp_valid at cycle 2 for a same-cycle slave. Throughput is one command per 3 cycles at best.
- Enables never assert in any state other than ISSUE, and never both at once.
- Reset mid-transaction: everything returns to reset values immediately. The host must reissue the command.

Test Plan:
- Write, addr 0x1004, data 0xA5A5_0001; slave asserts lb_wr_valid 3 cycles after lb_wr_en -> exactly one lb_wr_en pulse; lb_addr/lb_wr_data stable until the ack; rsp_valid with rsp_data = 0 and rsp_timeout = 0.
- Read, addr 0x2010; slave asserts lb_rd_valid in the same cycle as lb_rd_en with data 0x1234_5678 -> rsp_valid 2 cycles after command accept, rsp_data = 0x1234_5678.
- Read, TIMEOUT_CYCLES = 16, no slave response -> rsp_valid after 16 cycles of enable+wait; rsp_data = 0xDEADBABE, rsp_timeout = 1, tmo_cnt = 1.
- Boundary: valid on the 16th cycle -> normal response, no timeout. Valid on the 17th cycle -> timeout response; the late valid is ignored and the held rsp_data stays 0xDEADBABE.
- Back-pressure: rsp_ready held low for 10 cycles while cmd_valid stays high -> rsp fields stable; cmd_ready = 0 and no new enable until the handshake; the next command is accepted the cycle after return to IDLE.
- Wrong direction: write issued, slave returns lb_rd_valid only -> ignored, write times out. Separately, rst_n pulsed while in WAIT -> outputs go to reset values and cmd_ready = 1 after release.

Source files
------------

// File: rtl/lb_master.sv
// Local-bus initiator: turns one host command into one local-bus transaction and
// returns one response, with a per-transaction timeout so a dead slave cannot stall the host.
module lb_master #(
    parameter int unsigned          LB_DATA_W        = 32,
    parameter int unsigned          LB_ADDR_W        = 16,
    parameter int unsigned          TIMEOUT_CYCLES   = 64,
    parameter logic [LB_DATA_W-1:0] DEFAULT_DATA_VAL = 'hdeadbabe,
    parameter int unsigned          TMO_CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_wr,
    input  logic [LB_ADDR_W-1:0] cmd_addr,
    input  logic [LB_DATA_W-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [LB_DATA_W-1:0] rsp_data,
    output logic                 rsp_timeout,
    output logic                 lb_wr_en,
    output logic                 lb_rd_en,
    output logic [LB_ADDR_W-1:0] lb_addr,
    output logic [LB_DATA_W-1:0] lb_wr_data,
    input  logic                 lb_wr_valid,
    input  logic                 lb_rd_valid,
    input  logic [LB_DATA_W-1:0] lb_rd_data,
    output logic [TMO_CNT_W-1:0] tmo_cnt
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    logic                   is_wr_q, is_wr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   cmd_ready_d;
    logic                   rsp_valid_d;
    logic [LB_DATA_W-1:0]   rsp_data_d;
    logic                   rsp_timeout_d;
    logic                   lb_wr_en_d, lb_rd_en_d;
    logic [LB_ADDR_W-1:0]   lb_addr_d;
    logic [LB_DATA_W-1:0]   lb_wr_data_d;
    logic [TMO_CNT_W-1:0]   tmo_cnt_d;
    logic                   hit_c;

    // Only the valid matching the latched direction counts as an acknowledge.
    assign hit_c = is_wr_q ? lb_wr_valid : lb_rd_valid;

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        is_wr_d       = is_wr_q;
        cnt_d         = cnt_q;
        cmd_ready_d   = cmd_ready;
        rsp_valid_d   = rsp_valid;
        rsp_data_d    = rsp_data;
        rsp_timeout_d = rsp_timeout;
        lb_wr_en_d    = 1'b0;
        lb_rd_en_d    = 1'b0;
        lb_addr_d     = lb_addr;
        lb_wr_data_d  = lb_wr_data;
        tmo_cnt_d     = tmo_cnt;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    is_wr_d      = cmd_wr;
                    lb_addr_d    = cmd_addr;
                    lb_wr_data_d = cmd_wdata;
                    lb_wr_en_d   = cmd_wr;
                    lb_rd_en_d   = !cmd_wr;
                    cmd_ready_d  = 1'b0;
                    cnt_d        = '0;
                    state_d      = ISSUE;
                end
            end
            // The enable cycle is the first cycle of the timeout window.
            ISSUE, WAIT: begin
                if (hit_c) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_data_d    = is_wr_q ? '0 : lb_rd_data;
                    state_d       = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_data_d    = is_wr_q ? '0 : DEFAULT_DATA_VAL;
                    tmo_cnt_d     = (&tmo_cnt) ? tmo_cnt : tmo_cnt + TMO_CNT_W'(1);
                    state_d       = RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            cnt_q       <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            lb_wr_en    <= 1'b0;
            lb_rd_en    <= 1'b0;
            lb_addr     <= '0;
            lb_wr_data  <= '0;
            tmo_cnt     <= '0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            cnt_q       <= cnt_d;
            cmd_ready   <= cmd_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_data    <= rsp_data_d;
            rsp_timeout <= rsp_timeout_d;
            lb_wr_en    <= lb_wr_en_d;
            lb_rd_en    <= lb_rd_en_d;
            lb_addr     <= lb_addr_d;
            lb_wr_data  <= lb_wr_data_d;
            tmo_cnt     <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_lb_master.sv
// Bench for lb_master: table of single transactions against a scripted slave,
// plus hand-written back-pressure and mid-transaction reset sequences.
module tb_lb_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        lb_wr_en;
    logic        lb_rd_en;
    logic [15:0] lb_addr;
    logic [31:0] lb_wr_data;
    logic        lb_wr_valid;
    logic        lb_rd_valid;
    logic [31:0] lb_rd_data;
    logic [15:0] tmo_cnt;

    int checks;
    int errors;

    lb_master #(
        .LB_DATA_W       (32),
        .LB_ADDR_W       (16),
        .TIMEOUT_CYCLES  (16),
        .DEFAULT_DATA_VAL(32'hdeadbabe),
        .TMO_CNT_W       (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_wr     (cmd_wr),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_timeout(rsp_timeout),
        .lb_wr_en   (lb_wr_en),
        .lb_rd_en   (lb_rd_en),
        .lb_addr    (lb_addr),
        .lb_wr_data (lb_wr_data),
        .lb_wr_valid(lb_wr_valid),
        .lb_rd_valid(lb_rd_valid),
        .lb_rd_data (lb_rd_data),
        .tmo_cnt    (tmo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = slave silent, 1 = lb_wr_valid, 2 = lb_rd_valid.
    // delay: cycles after the enable cycle at which the slave pulses its valid.
    // exp_lat: number of enable+wait cycles before rsp_valid shows up.
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          delay;
        int          kind;
        logic [31:0] rdata;
        int          exp_lat;
        logic [31:0] exp_data;
        logic        exp_tmo;
        logic [15:0] exp_tcnt;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        lat = 0;
        cmd_valid = 1'b1;
        cmd_wr    = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        chk($sformatf("v%0d cmd_ready_idle", idx), 32'(cmd_ready), 32'(1));
        step();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (v.kind != 0 && k == v.delay + 1) begin
                lb_wr_valid = (v.kind == 1);
                lb_rd_valid = (v.kind == 2);
                lb_rd_data  = v.rdata;
            end
            if (k == 1) begin
                chk($sformatf("v%0d wr_en", idx), 32'(lb_wr_en), 32'(v.wr));
                chk($sformatf("v%0d rd_en", idx), 32'(lb_rd_en), 32'(!v.wr));
            end else if (lb_wr_en || lb_rd_en) begin
                chk($sformatf("v%0d en_wait", idx), {30'd0, lb_wr_en, lb_rd_en}, 32'd0);
            end
            chk($sformatf("v%0d addr", idx), 32'(lb_addr), 32'(v.addr));
            if (v.wr) chk($sformatf("v%0d wdata", idx), lb_wr_data, v.wdata);
            step();
            lb_wr_valid = 1'b0;
            lb_rd_valid = 1'b0;
            lb_rd_data  = 32'h0;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL v%0d rsp_wait: no rsp_valid within 40 cycles", idx);
            return;
        end
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("v%0d rsp_data", idx), rsp_data, v.exp_data);
        chk($sformatf("v%0d rsp_timeout", idx), 32'(rsp_timeout), 32'(v.exp_tmo));
        chk($sformatf("v%0d tmo_cnt", idx), 32'(tmo_cnt), 32'(v.exp_tcnt));
        chk($sformatf("v%0d cmd_ready_busy", idx), 32'(cmd_ready), 32'(0));
        // A valid scheduled after the timeout lands while the response is held.
        if (v.kind != 0 && v.delay >= lat) begin
            lb_wr_valid = (v.kind == 1);
            lb_rd_valid = (v.kind == 2);
            lb_rd_data  = v.rdata;
            step();
            lb_wr_valid = 1'b0;
            lb_rd_valid = 1'b0;
            lb_rd_data  = 32'h0;
            chk($sformatf("v%0d stray_valid", idx), 32'(rsp_valid), 32'(1));
            chk($sformatf("v%0d stray_data", idx), rsp_data, v.exp_data);
            chk($sformatf("v%0d stray_tmo", idx), 32'(rsp_timeout), 32'(v.exp_tmo));
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk($sformatf("v%0d rsp_drop", idx), 32'(rsp_valid), 32'(0));
        chk($sformatf("v%0d cmd_ready_back", idx), 32'(cmd_ready), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_wr      = 1'b0;
        cmd_addr    = 16'h0;
        cmd_wdata   = 32'h0;
        rsp_ready   = 1'b0;
        lb_wr_valid = 1'b0;
        lb_rd_valid = 1'b0;
        lb_rd_data  = 32'h0;

        //            wr    addr      wdata          dly kind rdata          lat data           tmo   tcnt
        vecs[0] = '{1'b1, 16'h1004, 32'ha5a5_0001,  3, 1, 32'h0,          4, 32'h0,          1'b0, 16'd0};
        vecs[1] = '{1'b0, 16'h2010, 32'h0,          0, 2, 32'h1234_5678,  1, 32'h1234_5678,  1'b0, 16'd0};
        vecs[2] = '{1'b0, 16'h3000, 32'h0,          0, 0, 32'h0,         16, 32'hdead_babe,  1'b1, 16'd1};
        vecs[3] = '{1'b0, 16'h3004, 32'h0,         15, 2, 32'hcafe_f00d, 16, 32'hcafe_f00d,  1'b0, 16'd1};
        vecs[4] = '{1'b0, 16'h3008, 32'h0,         16, 2, 32'h0bad_f00d, 16, 32'hdead_babe,  1'b1, 16'd2};
        vecs[5] = '{1'b1, 16'h4000, 32'h1111_2222,  2, 2, 32'h5555_aaaa, 16, 32'h0,          1'b1, 16'd3};
        vecs[6] = '{1'b1, 16'h4004, 32'h3333_4444,  0, 1, 32'h0,          1, 32'h0,          1'b0, 16'd3};
        vecs[7] = '{1'b0, 16'h5000, 32'h0,          5, 1, 32'h9999_9999, 16, 32'hdead_babe,  1'b1, 16'd4};
        vecs[8] = '{1'b0, 16'h5004, 32'h0,          7, 2, 32'h8765_4321,  8, 32'h8765_4321,  1'b0, 16'd4};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst cmd_ready", 32'(cmd_ready), 32'(1));
        chk("rst rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst rsp_data", rsp_data, 32'h0);
        chk("rst enables", {30'd0, lb_wr_en, lb_rd_en}, 32'd0);
        chk("rst lb_addr", 32'(lb_addr), 32'h0);
        chk("rst tmo_cnt", 32'(tmo_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Back-pressure: response held while the next command waits on cmd_valid
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 16'h6000;
        cmd_wdata = 32'h0;
        step();
        chk("bp rd_en", 32'(lb_rd_en), 32'(1));
        lb_rd_valid = 1'b1;
        lb_rd_data  = 32'h600d_d00d;
        cmd_wr      = 1'b1;
        cmd_addr    = 16'h7000;
        cmd_wdata   = 32'h7777_0000;
        step();
        lb_rd_valid = 1'b0;
        lb_rd_data  = 32'h0;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("bp%0d rsp_valid", c), 32'(rsp_valid), 32'(1));
            chk($sformatf("bp%0d rsp_data", c), rsp_data, 32'h600d_d00d);
            chk($sformatf("bp%0d rsp_timeout", c), 32'(rsp_timeout), 32'(0));
            chk($sformatf("bp%0d cmd_ready", c), 32'(cmd_ready), 32'(0));
            chk($sformatf("bp%0d enables", c), {30'd0, lb_wr_en, lb_rd_en}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp idle rsp_valid", 32'(rsp_valid), 32'(0));
        chk("bp idle cmd_ready", 32'(cmd_ready), 32'(1));
        chk("bp idle enables", {30'd0, lb_wr_en, lb_rd_en}, 32'd0);
        step();
        cmd_valid = 1'b0;
        chk("bp2 wr_en", 32'(lb_wr_en), 32'(1));
        chk("bp2 rd_en", 32'(lb_rd_en), 32'(0));
        chk("bp2 addr", 32'(lb_addr), 32'h7000);
        chk("bp2 wdata", lb_wr_data, 32'h7777_0000);
        chk("bp2 cmd_ready", 32'(cmd_ready), 32'(0));
        lb_wr_valid = 1'b1;
        step();
        lb_wr_valid = 1'b0;
        chk("bp2 rsp_valid", 32'(rsp_valid), 32'(1));
        chk("bp2 rsp_data", rsp_data, 32'h0);
        chk("bp2 rsp_timeout", 32'(rsp_timeout), 32'(0));
        chk("bp2 tmo_cnt", 32'(tmo_cnt), 32'd4);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Reset while waiting on a silent slave
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 16'h8000;
        step();
        cmd_valid = 1'b0;
        repeat (5) step();
        chk("mid cmd_ready", 32'(cmd_ready), 32'(0));
        rst_n = 1'b0;
        #1;
        chk("mrst cmd_ready", 32'(cmd_ready), 32'(1));
        chk("mrst lb_addr", 32'(lb_addr), 32'h0);
        chk("mrst enables", {30'd0, lb_wr_en, lb_rd_en}, 32'd0);
        chk("mrst rsp_valid", 32'(rsp_valid), 32'(0));
        chk("mrst rsp_data", rsp_data, 32'h0);
        chk("mrst tmo_cnt", 32'(tmo_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            step();
            chk("post cmd_ready", 32'(cmd_ready), 32'(1));
            chk("post rsp_valid", 32'(rsp_valid), 32'(0));
            chk("post enables", {30'd0, lb_wr_en, lb_rd_en}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
